debounce_multi: RTL and testbench

Parametrised multi-channel switch debouncer. It is the next generation of the single-switch debouncer in the UART board front end. It synchronises NCH asynchronous switch or button inputs, filters each one with a shared millisecond-class tick prescaler and a per-channel stability counter, and outputs a clean level per channel. Unlike the single-channel block, it is symmetric in both directions, configurable in channel count, tick period and stability window, and emits one-cycle rise and fall pulses for downstream control logic.

---
 rtl/debounce_pkg.sv | 14 +
 rtl/debounce_multi_if.sv | 13 +
 rtl/debounce_chan.sv | 69 ++++++
 rtl/debounce_multi.sv | 54 +++++
 tb/tb_debounce_multi.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared defaults and helpers for the multi-channel switch debouncer.
package debounce_pkg;

  localparam int unsigned DefaultTickDiv     = 1000000;
  localparam int unsigned DefaultStableTicks = 3;

  // Number of clock cycles spanning ms milliseconds at clk_hz.
  function automatic int unsigned ms_to_ticks(input int unsigned clk_hz, input int unsigned ms);
    longint unsigned cycles;
    cycles = (longint'(clk_hz) / 64'd1000) * longint'(ms);
    return int'(cycles[31:0]);
  endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Switch inputs and debounced outputs of debounce_multi, bundled for port connection.
interface debounce_multi_if #(
  parameter int unsigned NCH = 4
);
  logic [NCH-1:0] sw;
  logic [NCH-1:0] level;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;
  logic           tick;

  modport master (output sw, input level, input rise, input fall, input tick);
  modport slave  (input sw, output level, output rise, output fall, output tick);
endinterface

// File: rtl/debounce_chan.sv
// One debounced channel: two-flop synchroniser, tick-based stability counter,
// registered level and one-cycle rise/fall pulses.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DefaultStableTicks,
  parameter logic        INIT_LEVEL   = 1'b0
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic tick_i,
  input  logic sw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned     CntW   = $clog2(STABLE_TICKS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_TICKS - 1);

  logic            s1_q, s2_q;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Any sample agreeing with the current level restarts the stability window.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CntMax) begin
        level_d = s2_q;
        cnt_d   = '0;
        rise_d  = s2_q;
        fall_d  = ~s2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= INIT_LEVEL;
      s2_q    <= INIT_LEVEL;
      level_q <= INIT_LEVEL;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= sw_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: one shared tick prescaler feeding NCH
// independent debounce_chan instances.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int unsigned NCH          = 4,
  parameter int unsigned TICK_DIV     = DefaultTickDiv,
  parameter int unsigned STABLE_TICKS = DefaultStableTicks,
  parameter logic        INIT_LEVEL   = 1'b0
) (
  input logic             clk_in,
  input logic             reset_n,
  debounce_multi_if.slave sw_if
);

  localparam int unsigned     DivW   = $clog2(TICK_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic            tick;
  logic [NCH-1:0]  level_w, rise_w, fall_w;

  assign tick  = (div_q == DivMax);
  assign div_d = tick ? '0 : div_q + DivW'(1);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  for (genvar i = 0; i < int'(NCH); i++) begin : g_chan
    debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS),
      .INIT_LEVEL  (INIT_LEVEL)
    ) u_chan (
      .clk_in (clk_in),
      .reset_n(reset_n),
      .tick_i (tick),
      .sw_i   (sw_if.sw[i]),
      .level_o(level_w[i]),
      .rise_o (rise_w[i]),
      .fall_o (fall_w[i])
    );
  end

  assign sw_if.level = level_w;
  assign sw_if.rise  = rise_w;
  assign sw_if.fall  = fall_w;
  assign sw_if.tick  = tick;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed and random stimulus for two debouncers (INIT_LEVEL 0 and 1) checked
// against a cycle-level reference model of the debounce rules.
module tb_debounce_multi;
  localparam int unsigned NCH = 4;
  localparam int unsigned TD  = 4;
  localparam int unsigned ST  = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] sw = '0;
  int             errors = 0;
  int             checks = 0;

  always #5 clk = ~clk;

  debounce_multi_if #(.NCH(NCH)) bus0 ();
  debounce_multi_if #(.NCH(NCH)) bus1 ();
  assign bus0.sw = sw;
  assign bus1.sw = sw;

  debounce_multi #(.NCH(NCH), .TICK_DIV(TD), .STABLE_TICKS(ST), .INIT_LEVEL(1'b0)) dut0 (
    .clk_in (clk),
    .reset_n(rst_n),
    .sw_if  (bus0)
  );
  debounce_multi #(.NCH(NCH), .TICK_DIV(TD), .STABLE_TICKS(ST), .INIT_LEVEL(1'b1)) dut1 (
    .clk_in (clk),
    .reset_n(rst_n),
    .sw_if  (bus1)
  );

  // Reference model: sampled-input history, cycles since reset, and for every
  // channel how many ticks the synchronised input has disagreed with the level.
  logic [NCH-1:0] m_s1[2], m_s2[2], m_level[2], m_rise[2], m_fall[2];
  int             m_run[2][NCH];
  int             m_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k]    = (k == 0) ? '0 : '1;
      m_s2[k]    = m_s1[k];
      m_level[k] = m_s1[k];
      m_rise[k]  = '0;
      m_fall[k]  = '0;
      for (int i = 0; i < NCH; i++) m_run[k][i] = 0;
    end
    m_cycles = 0;
  endtask

  task automatic model_edge();
    bit tick_now;
    tick_now = ((m_cycles % TD) == TD - 1);
    for (int k = 0; k < 2; k++) begin
      m_rise[k] = '0;
      m_fall[k] = '0;
      for (int i = 0; i < NCH; i++) begin
        if (m_s2[k][i] == m_level[k][i]) begin
          m_run[k][i] = 0;
        end else if (tick_now) begin
          m_run[k][i] = m_run[k][i] + 1;
          if (m_run[k][i] == ST) begin
            m_level[k][i] = m_s2[k][i];
            m_run[k][i]   = 0;
            m_rise[k][i]  = m_s2[k][i];
            m_fall[k][i]  = !m_s2[k][i];
          end
        end
      end
      m_s2[k] = m_s1[k];
      m_s1[k] = sw;
    end
    m_cycles++;
  endtask

  task automatic check_all();
    chk("level0", bus0.level, m_level[0]);
    chk("rise0", bus0.rise, m_rise[0]);
    chk("fall0", bus0.fall, m_fall[0]);
    chk("level1", bus1.level, m_level[1]);
    chk("rise1", bus1.rise, m_rise[1]);
    chk("fall1", bus1.fall, m_fall[1]);
    chk("tick0", bus0.tick, ((m_cycles % TD) == TD - 1));
    chk("tick1", bus1.tick, ((m_cycles % TD) == TD - 1));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic settle(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  // Edges from the first sampling edge until dut0 channel ch reaches target,
  // and the number of matching pulses seen; lat stays -1 if never reached.
  task automatic measure(input int ch, input bit target, output int lat, output int pulses);
    lat    = -1;
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      cycle();
      if (bus0.level[ch] == target && lat < 0) lat = n;
      if (target ? bus0.rise[ch] : bus0.fall[ch]) pulses++;
    end
  endtask

  initial begin
    int lat, pulses, bad, found;
    model_reset();

    // Reset with all switches high, then release.
    sw    = 4'hF;
    rst_n = 1'b0;
    settle(3);
    chk("rst_level0", bus0.level, 4'h0);
    chk("rst_level1", bus1.level, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      cycle();
      chk("first_tick", bus0.tick, (n == 3));
      chk("release_no_pulse", bus0.rise | bus0.fall | bus1.rise | bus1.fall, 4'h0);
    end
    sw = 4'h0;
    settle(20);

    // Clean press on channel 0.
    sw = 4'h1;
    measure(0, 1'b1, lat, pulses);
    chk("press_lat_window", (lat >= 10 && lat <= 13), 1);
    chk("press_one_rise", pulses, 1);
    chk("press_others", bus0.level[3:1], 3'b000);

    // Bounce on channel 1, then settle high.
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (c % 3 == 0) sw[1] = !sw[1];
      cycle();
      if (bus0.level[1]) bad = 1;
    end
    chk("bounce_held_low", bad, 0);
    sw[1] = 1'b1;
    measure(1, 1'b1, lat, pulses);
    chk("bounce_settle_lat", (lat >= 0 && lat <= 13), 1);
    chk("bounce_one_rise", pulses, 1);

    // Release on channel 2.
    sw[2] = 1'b1;
    settle(16);
    chk("ch2_high", bus0.level[2], 1'b1);
    sw[2] = 1'b0;
    measure(2, 1'b0, lat, pulses);
    chk("release_lat_window", (lat >= 10 && lat <= 13), 1);
    chk("release_one_fall", pulses, 1);

    // Simultaneous flip of all channels.
    sw = 4'h0;
    settle(16);
    sw    = 4'hF;
    found = 0;
    for (int n = 0; n < 16 && !found; n++) begin
      cycle();
      if (bus0.level != 4'h0) found = 1;
    end
    chk("simul_found", found, 1);
    chk("simul_level", bus0.level, 4'hF);
    chk("simul_rise", bus0.rise, 4'hF);
    cycle();
    chk("simul_rise_once", bus0.rise, 4'h0);

    // Reset while channel 3 is mid-count.
    sw = 4'h0;
    settle(16);
    sw = 4'h8;
    settle(8);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_level0", bus0.level, 4'h0);
    chk("midrst_level1", bus1.level, 4'hF);
    chk("midrst_pulses", bus0.rise | bus0.fall | bus1.rise | bus1.fall, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    measure(3, 1'b1, lat, pulses);
    chk("midrst_lat_window", (lat >= 10 && lat <= 13), 1);
    chk("midrst_one_rise", pulses, 1);

    // Random toggling with occasional resets.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(11) == 0) sw[i] = !sw[i];
      end
      if ($urandom_range(199) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
